matrix_load_unit: RTL and testbench

- Writer-side producer for the matrix register file: fetches a 4-word matrix from data memory and writes it back through the regfile write port (w_select / w_regs_addr / w_regs_data / w_matrix_data).
- Sits between the MEM stage and the regfile.
- Two modes:
  - whole-matrix: one w_select=11 write after all four words arrive.
  - slice: one w_select=10 write per word as it arrives.

---
 rtl/matrix_load_unit_if.sv | 35 +++
 rtl/matrix_load_unit.sv | 169 ++++++++++++++++
 tb/tb_matrix_load_unit.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/matrix_load_unit_if.sv
// Bundle of the request, memory and regfile-write signals of the matrix load unit.
// master: the load unit itself; slave: the surrounding pipeline / memory / regfile.
interface matrix_load_unit_if #(
  parameter int unsigned SLICES = 4
);
  // Pipeline-side request
  logic                  start;
  logic                  mode;
  logic [31:0]           base_addr;
  logic                  flush;
  // Data-memory read port
  logic                  mem_req;
  logic [31:0]           mem_addr;
  logic                  mem_gnt;
  logic                  mem_rvalid;
  logic [31:0]           mem_rdata;
  // Status
  logic                  busy;
  logic                  done;
  // Regfile write port
  logic [1:0]            w_select;
  logic [4:0]            w_regs_addr;
  logic [31:0]           w_regs_data;
  logic [32*SLICES-1:0]  w_matrix_data;

  modport master (
    input  start, mode, base_addr, flush, mem_gnt, mem_rvalid, mem_rdata,
    output mem_req, mem_addr, busy, done, w_select, w_regs_addr, w_regs_data, w_matrix_data
  );

  modport slave (
    output start, mode, base_addr, flush, mem_gnt, mem_rvalid, mem_rdata,
    input  mem_req, mem_addr, busy, done, w_select, w_regs_addr, w_regs_data, w_matrix_data
  );
endinterface

// File: rtl/matrix_load_unit.sv
// Matrix load unit: fetches SLICES consecutive words from data memory and writes them
// into the matrix register file, either as one whole-matrix write or one write per slice.
// Memory reads may be pipelined (up to SLICES outstanding); responses return in order.
module matrix_load_unit #(
  parameter int unsigned SLICES     = 4,
  parameter int unsigned WORD_BYTES = 4
) (
  input logic                clk,
  input logic                rst,
  matrix_load_unit_if.master bus
);

  localparam int unsigned CntW = $clog2(SLICES + 1);
  localparam int unsigned IdxW = $clog2(SLICES);

  localparam logic [1:0] SelNone  = 2'b00;
  localparam logic [1:0] SelSlice = 2'b10;
  localparam logic [1:0] SelWhole = 2'b11;

  typedef enum logic [1:0] {StIdle, StFetch, StWrite, StDrain} state_e;

  state_e                state;
  logic [31:0]           base_q;
  logic                  mode_q;
  logic [CntW-1:0]       issue_cnt;
  logic [CntW-1:0]       rcv_cnt;
  logic [31:0]           buffer [SLICES];

  logic                  done_q;
  logic [1:0]            w_select_q;
  logic [4:0]            w_regs_addr_q;
  logic [31:0]           w_regs_data_q;
  logic [32*SLICES-1:0]  w_matrix_data_q;

  logic                  issue_more;
  logic                  grant;
  logic                  rsp_ok;
  logic                  last_rsp;
  logic [CntW-1:0]       issue_after;
  logic [CntW-1:0]       rcv_after;
  logic [32*SLICES-1:0]  matrix_next;

  // Handshake decode; a response only counts while a request is actually outstanding,
  // which also discards stray rvalids in IDLE and after a reset.
  always_comb begin
    issue_more  = (state == StFetch) && (issue_cnt < CntW'(SLICES));
    grant       = issue_more && bus.mem_gnt;
    rsp_ok      = ((state == StFetch) || (state == StDrain)) && bus.mem_rvalid &&
                  (rcv_cnt < issue_cnt);
    last_rsp    = rsp_ok && (rcv_cnt == CntW'(SLICES - 1));
    issue_after = issue_cnt + CntW'(grant);
    rcv_after   = rcv_cnt + CntW'(rsp_ok);
  end

  // Whole-matrix image with the arriving last word placed in the top slot.
  always_comb begin
    matrix_next = '0;
    for (int i = 0; i < int'(SLICES); i++) begin
      if (i == int'(SLICES) - 1) begin
        matrix_next[32*i +: 32] = bus.mem_rdata;
      end else begin
        matrix_next[32*i +: 32] = buffer[IdxW'(i)];
      end
    end
  end

  // State-decoded outputs.
  always_comb begin
    bus.mem_req  = issue_more;
    bus.mem_addr = '0;
    if (state == StFetch) begin
      bus.mem_addr = base_q + 32'(WORD_BYTES) * 32'(issue_cnt);
    end
    bus.busy = (state != StIdle);
  end

  // Registered outputs.
  always_comb begin
    bus.done          = done_q;
    bus.w_select      = w_select_q;
    bus.w_regs_addr   = w_regs_addr_q;
    bus.w_regs_data   = w_regs_data_q;
    bus.w_matrix_data = w_matrix_data_q;
  end

  // Control FSM, counters, word buffer and registered regfile-write outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= StIdle;
      base_q          <= '0;
      mode_q          <= 1'b0;
      issue_cnt       <= '0;
      rcv_cnt         <= '0;
      for (int i = 0; i < int'(SLICES); i++) begin
        buffer[i] <= '0;
      end
      done_q          <= 1'b0;
      w_select_q      <= SelNone;
      w_regs_addr_q   <= '0;
      w_regs_data_q   <= '0;
      w_matrix_data_q <= '0;
    end else begin
      // Write outputs are single-cycle pulses; idle values are all zero.
      done_q          <= 1'b0;
      w_select_q      <= SelNone;
      w_regs_addr_q   <= '0;
      w_regs_data_q   <= '0;
      w_matrix_data_q <= '0;

      if (grant) begin
        issue_cnt <= issue_after;
      end
      if (rsp_ok) begin
        buffer[rcv_cnt[IdxW-1:0]] <= bus.mem_rdata;
        rcv_cnt                   <= rcv_after;
      end

      unique case (state)
        StIdle: begin
          // Start beats a simultaneous flush; flush alone has nothing to abort.
          if (bus.start) begin
            base_q    <= {bus.base_addr[31:2], 2'b00};
            mode_q    <= bus.mode;
            issue_cnt <= '0;
            rcv_cnt   <= '0;
            state     <= StFetch;
          end
        end

        StFetch: begin
          if (bus.flush) begin
            // Any request granted up to and including this edge will still respond.
            state <= (issue_after > rcv_after) ? StDrain : StIdle;
          end else if (rsp_ok) begin
            if (mode_q) begin
              w_select_q    <= SelSlice;
              w_regs_addr_q <= 5'(rcv_cnt);
              w_regs_data_q <= bus.mem_rdata;
              if (last_rsp) begin
                done_q <= 1'b1;
                state  <= StIdle;
              end
            end else if (last_rsp) begin
              w_select_q      <= SelWhole;
              w_matrix_data_q <= matrix_next;
              done_q          <= 1'b1;
              state           <= StWrite;
            end
          end
        end

        StWrite: begin
          // Whole-matrix write is visible during this state; one cycle only.
          state <= StIdle;
        end

        StDrain: begin
          // Swallow the responses of the aborted load, then return to idle.
          if (rcv_after == issue_cnt) begin
            state <= StIdle;
          end
        end

        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_load_unit.sv
// Directed testbench for matrix_load_unit with a small in-order memory responder.
module tb_matrix_load_unit;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  matrix_load_unit_if #(.SLICES(4)) bus ();

  matrix_load_unit #(
    .SLICES     (4),
    .WORD_BYTES (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [1:0]   sel;
    logic [4:0]   raddr;
    logic [31:0]  rdata;
    logic [127:0] matrix;
    logic         done;
  } ev_t;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  ev_t         ev_q [$];
  logic [31:0] addr_q [$];
  logic [31:0] rsp_q [$];
  int          grant_idx, rsp_given, rsp_limit;
  int          idle_viol, hold_viol;
  int          start_cyc, done_cyc;
  logic        done_seen, start_busy;
  logic        start_pulse = 1'b0, flush_pulse = 1'b0, stray_pulse = 1'b0;
  logic        gnt_alt = 1'b0, gnt_phase = 1'b1;
  logic        hold_pending = 1'b0;
  logic [31:0] hold_addr;

  localparam logic [127:0] ExpMatrix = 128'h44444444_33333333_22222222_11111111;

  task automatic prepare();
    ev_q.delete();
    addr_q.delete();
    rsp_q.delete();
    grant_idx    = 0;
    rsp_given    = 0;
    rsp_limit    = 1000;
    done_seen    = 1'b0;
    done_cyc     = -1;
    idle_viol    = 0;
    hold_viol    = 0;
    gnt_alt      = 1'b0;
    gnt_phase    = 1'b1;
    hold_pending = 1'b0;
  endtask

  // One clock cycle: observe this cycle's outputs at the falling edge, then drive inputs.
  task automatic cycle();
    ev_t e;
    @(negedge clk);
    cyc++;
    if (bus.w_select != 2'b00) begin
      e.sel    = bus.w_select;
      e.raddr  = bus.w_regs_addr;
      e.rdata  = bus.w_regs_data;
      e.matrix = bus.w_matrix_data;
      e.done   = bus.done;
      ev_q.push_back(e);
    end
    if (bus.done) begin
      done_seen = 1'b1;
      done_cyc  = cyc;
    end
    if ((bus.w_select != 2'b10 && (bus.w_regs_data != 32'h0 || bus.w_regs_addr != 5'h0)) ||
        (bus.w_select != 2'b11 && bus.w_matrix_data != 128'h0) || bus.w_select == 2'b01)
      idle_viol++;
    if (hold_pending && (!bus.mem_req || bus.mem_addr != hold_addr)) hold_viol++;

    bus.start = start_pulse;
    if (start_pulse) start_cyc = cyc;
    start_pulse = 1'b0;
    bus.flush   = flush_pulse;
    flush_pulse = 1'b0;

    if (stray_pulse) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'hDEADBEEF;
      stray_pulse    = 1'b0;
    end else if (rsp_q.size() > 0 && rsp_given < rsp_limit) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = rsp_q.pop_front();
      rsp_given++;
    end else begin
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = 32'hBAD0BAD0;
    end

    if (gnt_alt) begin
      gnt_phase   = !gnt_phase;
      bus.mem_gnt = gnt_phase;
    end else begin
      bus.mem_gnt = 1'b1;
    end
    hold_pending = bus.mem_req && !bus.mem_gnt;
    hold_addr    = bus.mem_addr;
    if (bus.mem_req && bus.mem_gnt) begin
      addr_q.push_back(bus.mem_addr);
      rsp_q.push_back(32'h11111111 * 32'(grant_idx + 1));
      grant_idx++;
    end
  endtask

  task automatic run_load(input logic [31:0] base, input logic m, input logic alt);
    prepare();
    bus.base_addr = base;
    bus.mode      = m;
    gnt_alt       = alt;
    start_pulse   = 1'b1;
    cycle();
    start_busy = bus.busy;
    for (int i = 0; i < 40 && !done_seen; i++) cycle();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #12;
    n_checks++;
    if ({bus.mem_req, bus.busy, bus.done, bus.w_select} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got req/busy/done/sel=%b want 00000",
               {bus.mem_req, bus.busy, bus.done, bus.w_select});
    end
    n_checks++;
    if (bus.mem_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_addr: got %h want 0", bus.mem_addr);
    end
    n_checks++;
    if ({bus.w_regs_addr, bus.w_regs_data} !== 37'h0) begin
      n_fail++;
      $display("FAIL reset_regs: got %h/%h want 0", bus.w_regs_addr, bus.w_regs_data);
    end
    n_checks++;
    if (bus.w_matrix_data !== 128'h0) begin
      n_fail++;
      $display("FAIL reset_matrix: got %h want 0", bus.w_matrix_data);
    end
    @(negedge clk);
    rst = 1'b1;
    prepare();
    bus.flush = 1'b0;
    flush_pulse = 1'b1;   // flush in IDLE must do nothing
    cycle();
    cycle();
    n_checks++;
    if (bus.busy !== 1'b0 || ev_q.size() != 0) begin
      n_fail++;
      $display("FAIL idle_flush: got busy=%b writes=%0d want 0/0", bus.busy, ev_q.size());
    end
  endtask

  task automatic test_whole();
    run_load(32'h100, 1'b0, 1'b0);
    n_checks++;
    if (!done_seen || done_cyc - start_cyc != 6) begin
      n_fail++;
      $display("FAIL whole_latency: got done_seen=%b latency=%0d want 1/6",
               done_seen, done_cyc - start_cyc);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (addr_q.size() <= i || addr_q[i] !== 32'h100 + 32'(4 * i)) begin
        n_fail++;
        $display("FAIL whole_addr%0d: got %h want %h", i,
                 (addr_q.size() > i) ? addr_q[i] : 32'hx, 32'h100 + 32'(4 * i));
      end
    end
    n_checks++;
    if (ev_q.size() != 1 || ev_q[0].sel !== 2'b11 || ev_q[0].matrix !== ExpMatrix ||
        ev_q[0].done !== 1'b1) begin
      n_fail++;
      $display("FAIL whole_write: got n=%0d sel=%b m=%h done=%b want 1/11/%h/1", ev_q.size(),
               (ev_q.size() > 0) ? ev_q[0].sel : 2'bx,
               (ev_q.size() > 0) ? ev_q[0].matrix : 128'hx,
               (ev_q.size() > 0) ? ev_q[0].done : 1'bx, ExpMatrix);
    end
    cycle();
    n_checks++;
    if (bus.busy !== 1'b0 || ev_q.size() != 1 || idle_viol != 0) begin
      n_fail++;
      $display("FAIL whole_after: got busy=%b writes=%0d idle_viol=%0d want 0/1/0",
               bus.busy, ev_q.size(), idle_viol);
    end
  endtask

  task automatic test_back_to_back();
    run_load(32'h100, 1'b0, 1'b0);
    // Second start lands in the cycle right after done.
    run_load(32'h300, 1'b0, 1'b0);
    n_checks++;
    if (start_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_busy: got busy=%b in cycle after done want 0", start_busy);
    end
    n_checks++;
    if (!done_seen || done_cyc - start_cyc != 6 || addr_q.size() == 0 ||
        addr_q[0] !== 32'h300) begin
      n_fail++;
      $display("FAIL b2b_second: got done=%b latency=%0d first_addr=%h want 1/6/300",
               done_seen, done_cyc - start_cyc, (addr_q.size() > 0) ? addr_q[0] : 32'hx);
    end
    n_checks++;
    if (ev_q.size() != 1 || ev_q[0].matrix !== ExpMatrix) begin
      n_fail++;
      $display("FAIL b2b_matrix: got n=%0d want 1 with %h", ev_q.size(), ExpMatrix);
    end
    cycle();
  endtask

  task automatic test_slice();
    run_load(32'h203, 1'b1, 1'b0);
    cycle();
    cycle();
    n_checks++;
    if (addr_q.size() != 4 || addr_q[0] !== 32'h200 || addr_q[3] !== 32'h20C) begin
      n_fail++;
      $display("FAIL slice_addr: got n=%0d first=%h want 4 from 200 to 20c", addr_q.size(),
               (addr_q.size() > 0) ? addr_q[0] : 32'hx);
    end
    n_checks++;
    if (ev_q.size() != 4) begin
      n_fail++;
      $display("FAIL slice_count: got %0d writes want 4", ev_q.size());
    end
    for (int i = 0; i < 4 && i < ev_q.size(); i++) begin
      n_checks++;
      if (ev_q[i].sel !== 2'b10 || ev_q[i].raddr !== 5'(i) ||
          ev_q[i].rdata !== 32'h11111111 * 32'(i + 1) || ev_q[i].done !== (i == 3)) begin
        n_fail++;
        $display("FAIL slice_write%0d: got sel=%b a=%0d d=%h done=%b want 10/%0d/%h/%b", i,
                 ev_q[i].sel, ev_q[i].raddr, ev_q[i].rdata, ev_q[i].done, i,
                 32'h11111111 * 32'(i + 1), (i == 3));
      end
    end
    n_checks++;
    if (idle_viol != 0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL slice_idle: got idle_viol=%0d busy=%b want 0/0", idle_viol, bus.busy);
    end
  endtask

  task automatic test_backpressure();
    run_load(32'h100, 1'b0, 1'b1);
    n_checks++;
    if (!done_seen || ev_q.size() != 1 || ev_q[0].sel !== 2'b11 ||
        ev_q[0].matrix !== ExpMatrix) begin
      n_fail++;
      $display("FAIL bp_result: got done=%b writes=%0d want 1/1 with %h", done_seen,
               ev_q.size(), ExpMatrix);
    end
    n_checks++;
    if (addr_q.size() != 4 || addr_q[1] !== 32'h104 || addr_q[3] !== 32'h10C) begin
      n_fail++;
      $display("FAIL bp_addr: got n=%0d want 100..10c", addr_q.size());
    end
    n_checks++;
    if (hold_viol != 0) begin
      n_fail++;
      $display("FAIL bp_hold: got %0d address changes while waiting want 0", hold_viol);
    end
    cycle();
  endtask

  task automatic test_flush();
    prepare();
    bus.base_addr = 32'h400;
    bus.mode      = 1'b0;
    rsp_limit     = 2;
    start_pulse   = 1'b1;
    cycle();
    for (int i = 0; i < 5; i++) cycle();
    n_checks++;
    if (grant_idx != 4 || rsp_given != 2 || bus.mem_req !== 1'b0 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_setup: got grants=%0d rsps=%0d req=%b busy=%b want 4/2/0/1",
               grant_idx, rsp_given, bus.mem_req, bus.busy);
    end
    flush_pulse = 1'b1;
    cycle();
    cycle();
    cycle();
    cycle();
    n_checks++;
    if (bus.busy !== 1'b1 || bus.mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_drain: got busy=%b req=%b want 1/0", bus.busy, bus.mem_req);
    end
    rsp_limit = 4;
    cycle();
    cycle();
    cycle();
    n_checks++;
    if (bus.busy !== 1'b0 || rsp_given != 4) begin
      n_fail++;
      $display("FAIL flush_idle: got busy=%b rsps=%0d want 0/4", bus.busy, rsp_given);
    end
    cycle();
    n_checks++;
    if (ev_q.size() != 0 || done_seen) begin
      n_fail++;
      $display("FAIL flush_nowrite: got writes=%0d done=%b want 0/0", ev_q.size(), done_seen);
    end
  endtask

  task automatic test_wrap();
    prepare();
    stray_pulse = 1'b1;
    cycle();
    cycle();
    n_checks++;
    if (ev_q.size() != 0 || bus.busy !== 1'b0 || done_seen) begin
      n_fail++;
      $display("FAIL stray_idle: got writes=%0d busy=%b want 0/0", ev_q.size(), bus.busy);
    end
    run_load(32'hFFFF_FFF8, 1'b0, 1'b0);
    n_checks++;
    if (addr_q.size() != 4 || addr_q[0] !== 32'hFFFF_FFF8 || addr_q[1] !== 32'hFFFF_FFFC ||
        addr_q[2] !== 32'h0 || addr_q[3] !== 32'h4) begin
      n_fail++;
      $display("FAIL wrap_addr: got n=%0d %h %h want fffffff8 fffffffc 0 4", addr_q.size(),
               (addr_q.size() > 2) ? addr_q[2] : 32'hx, (addr_q.size() > 3) ? addr_q[3] : 32'hx);
    end
    n_checks++;
    if (ev_q.size() != 1 || ev_q[0].matrix !== ExpMatrix) begin
      n_fail++;
      $display("FAIL wrap_matrix: got n=%0d want 1 with %h", ev_q.size(), ExpMatrix);
    end
    cycle();
    stray_pulse = 1'b1;
    cycle();
    cycle();
    n_checks++;
    if (ev_q.size() != 1 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL stray_after: got writes=%0d busy=%b want 1/0", ev_q.size(), bus.busy);
    end
  endtask

  task automatic test_reset_mid_fetch();
    prepare();
    bus.base_addr = 32'h500;
    bus.mode      = 1'b0;
    start_pulse   = 1'b1;
    cycle();
    cycle();
    cycle();
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({bus.mem_req, bus.busy, bus.done, bus.w_select} !== 5'b0 || bus.mem_addr !== 32'h0 ||
        bus.w_matrix_data !== 128'h0 || bus.w_regs_data !== 32'h0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got req=%b busy=%b addr=%h want all zero",
               bus.mem_req, bus.busy, bus.mem_addr);
    end
    n_checks++;
    if (grant_idx != 2) begin
      n_fail++;
      $display("FAIL midreset_grants: got %0d grants before reset want 2", grant_idx);
    end
    cycle();
    rst = 1'b1;
    stray_pulse = 1'b1;
    cycle();
    cycle();
    n_checks++;
    if (bus.busy !== 1'b0 || ev_q.size() != 0 || done_seen) begin
      n_fail++;
      $display("FAIL midreset_idle: got busy=%b writes=%0d want 0/0", bus.busy, ev_q.size());
    end
    run_load(32'h600, 1'b0, 1'b0);
    n_checks++;
    if (!done_seen || done_cyc - start_cyc != 6 || ev_q.size() != 1 ||
        ev_q[0].matrix !== ExpMatrix || addr_q.size() != 4 || addr_q[0] !== 32'h600) begin
      n_fail++;
      $display("FAIL midreset_reload: got done=%b latency=%0d writes=%0d want 1/6/1",
               done_seen, done_cyc - start_cyc, ev_q.size());
    end
    cycle();
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.mode       = 1'b0;
    bus.base_addr  = 32'h0;
    bus.flush      = 1'b0;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'h0;
    prepare();
    test_reset();
    test_whole();
    test_back_to_back();
    test_slice();
    test_backpressure();
    test_flush();
    test_wrap();
    test_reset_mid_fetch();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
